// File: rtl/dsp_pkg.sv
// Shared constants, FSM state encoding and pan-to-target-gain mapping for the
// mono-to-stereo panner.
`ifndef BITS
`define BITS 16
`endif

package dsp_pkg;

    localparam int BITS = `BITS;

    localparam logic [BITS-1:0] HALF = {2'b01, {(BITS-2){1'b0}}};
    localparam logic [BITS-1:0] GMAX = {1'b0, {(BITS-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_MUL_L,
        S_MUL_R,
        S_DONE
    } pan_state_t;

    typedef struct packed {
        logic [BITS-1:0] l;
        logic [BITS-1:0] r;
    } gain_pair_t;

    // Left target only wraps to 0x8000 at full-left pan; that one case clamps to GMAX.
    function automatic gain_pair_t pan_targets(input logic [BITS-1:0] pan);
        gain_pair_t      t;
        logic [BITS-1:0] p2;
        logic [BITS-1:0] tl;
        p2  = {pan[BITS-1], pan[BITS-1:1]};
        tl  = HALF - p2;
        t.r = HALF + p2;
        t.l = tl[BITS-1] ? GMAX : tl;
        return t;
    endfunction

endpackage

// File: rtl/dsp_slew.sv
// One slew-limited gain register: each enabled cycle moves the gain toward its
// target by at most RAMP_STEP, landing exactly on the target without overshoot.
module dsp_slew
    import dsp_pkg::*;
#(
    parameter int RAMP_STEP = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            step_en_i,
    input  logic [BITS-1:0] target_i,
    output logic [BITS-1:0] gain_o
);

    localparam logic [BITS-1:0]        STEP_W = BITS'(RAMP_STEP);
    localparam logic signed [BITS:0]   STEP_X = (BITS+1)'(RAMP_STEP);

    logic [BITS-1:0]      gain_q, gain_d;
    logic signed [BITS:0] diff;

    // Target and gain are both in 0..GMAX, so one extra bit holds the signed distance.
    assign diff = $signed({1'b0, target_i}) - $signed({1'b0, gain_q});

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gain_d = gain_q;
        if (step_en_i) begin
            if (diff > STEP_X) begin
                gain_d = gain_q + STEP_W;
            end else if (diff < -STEP_X) begin
                gain_d = gain_q - STEP_W;
            end else begin
                gain_d = target_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_q <= '0;
        end else begin
            gain_q <= gain_d;
        end
    end

    assign gain_o = gain_q;

endmodule

// File: rtl/dsp_pan2.sv
// Mono-to-stereo panner: slew-limited left/right gains applied to each accepted
// sample through a single multiplier shared over two FSM states.
module dsp_pan2
    import dsp_pkg::*;
#(
    parameter int RAMP_STEP = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] sig_in,
    input  logic [BITS-1:0] pan,
    output logic            out_valid,
    output logic [BITS-1:0] sig_out_l,
    output logic [BITS-1:0] sig_out_r,
    output logic [BITS-1:0] gain_l,
    output logic [BITS-1:0] gain_r
);

    pan_state_t state_q, state_d;

    logic [BITS-1:0] x_q, pan_q;
    logic [BITS-1:0] prod_l_q, prod_r_q;
    logic [BITS-1:0] out_l_q, out_r_q;
    logic            out_valid_q;

    gain_pair_t               tgt;
    logic [BITS-1:0]          mul_b;
    logic signed [2*BITS-1:0] mul_full;
    logic [BITS-1:0]          mul_res;
    logic                     unused_mul_bits;

    assign tgt = pan_targets(pan_q);

    dsp_slew #(.RAMP_STEP(RAMP_STEP)) u_slew_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en_i (state_q == S_RAMP),
        .target_i  (tgt.l),
        .gain_o    (gain_l)
    );

    dsp_slew #(.RAMP_STEP(RAMP_STEP)) u_slew_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en_i (state_q == S_RAMP),
        .target_i  (tgt.r),
        .gain_o    (gain_r)
    );

    // Shared multiplier; taking bits [2*BITS-2:BITS-1] is the >>> (BITS-1) with floor rounding.
    assign mul_b           = (state_q == S_MUL_R) ? gain_r : gain_l;
    assign mul_full        = $signed(x_q) * $signed(mul_b);
    assign mul_res         = mul_full[2*BITS-2:BITS-1];
    assign unused_mul_bits = ^{mul_full[2*BITS-1], mul_full[BITS-2:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RAMP;
            S_RAMP:  state_d = S_MUL_L;
            S_MUL_L: state_d = S_MUL_R;
            S_MUL_R: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            pan_q       <= '0;
            prod_l_q    <= '0;
            prod_r_q    <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q   <= sig_in;
                        pan_q <= pan;
                    end
                end
                S_MUL_L: prod_l_q <= mul_res;
                S_MUL_R: prod_r_q <= mul_res;
                S_DONE: begin
                    out_l_q     <= prod_l_q;
                    out_r_q     <= prod_r_q;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign sig_out_l = out_l_q;
    assign sig_out_r = out_r_q;

endmodule

// File: tb/tb_dsp_pan2.sv
// Self-checking bench for dsp_pan2 (BITS=16, RAMP_STEP=64): a cycle-level
// behavioural model compared every cycle, plus hand-computed literal checks.
`timescale 1ns/1ps

module tb_dsp_pan2;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] sig_in   = '0;
    logic signed [15:0] pan      = '0;
    logic               in_ready, out_valid;
    logic signed [15:0] sig_out_l, sig_out_r, gain_l, gain_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsp_pan2 #(.RAMP_STEP(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sig_in    (sig_in),
        .pan       (pan),
        .out_valid (out_valid),
        .sig_out_l (sig_out_l),
        .sig_out_r (sig_out_r),
        .gain_l    (gain_l),
        .gain_r    (gain_r)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_gl = 0, m_gr = 0, m_ol = 0, m_or = 0;
    int m_busy = 0, m_x = 0, m_p = 0;
    bit m_ov = 1'b0;

    function automatic int floor_q15(input longint prod);
        longint q;
        q = prod / 32768;
        if (prod < 0 && (prod % 32768) != 0) q = q - 1;
        return int'(q);
    endfunction

    function automatic int toward(input int g, input int t);
        if (t - g > 64) return g + 64;
        if (g - t > 64) return g - 64;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_gl = 0; m_gr = 0; m_ol = 0; m_or = 0;
            m_busy = 0; m_ov = 1'b0;
        end else begin
            m_ov = 1'b0;
            if (m_busy == 0) begin
                if (in_valid) begin
                    m_x    = int'(sig_in);
                    m_p    = int'(pan);
                    m_busy = 4;
                end
            end else begin
                if (m_busy == 4) begin
                    int half_p, tl, tr;
                    half_p = (m_p < 0) ? (m_p - 1) / 2 : m_p / 2;
                    tr     = 16384 + half_p;
                    tl     = 16384 - half_p;
                    if (tl > 32767) tl = 32767;
                    m_gl = toward(m_gl, tl);
                    m_gr = toward(m_gr, tr);
                end
                if (m_busy == 1) begin
                    m_ol = floor_q15(longint'(m_x) * longint'(m_gl));
                    m_or = floor_q15(longint'(m_x) * longint'(m_gr));
                    m_ov = 1'b1;
                end
                m_busy--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready",  int'(in_ready),  (m_busy == 0) ? 1 : 0);
            check("out_valid", int'(out_valid), int'(m_ov));
            check("gain_l",    int'(gain_l),    m_gl);
            check("gain_r",    int'(gain_r),    m_gr);
            check("sig_out_l", int'(sig_out_l), m_ol);
            check("sig_out_r", int'(sig_out_r), m_or);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_sample(input int x, input int p, output int lat);
        int guard;
        @(negedge clk);
        sig_in   = 16'(x);
        pan      = 16'(p);
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) timeout("accept");
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) timeout("out_valid");
    endtask

    task automatic run_samples(input int n, input int x, input int p);
        int lat;
        for (int i = 0; i < n; i++) do_sample(x, p, lat);
    endtask

    initial begin
        int lat;
        int acc[$];
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_gain_l",    int'(gain_l),    0);
        check("rst_sig_out_r", int'(sig_out_r), 0);
        rst_n = 1'b1;

        // Reset fade-in: one centre sample
        do_sample(16384, 0, lat);
        check("fadein_latency", lat, 5);
        check("fadein_gain_l",  int'(gain_l),    64);
        check("fadein_gain_r",  int'(gain_r),    64);
        check("fadein_out_l",   int'(sig_out_l), 32);
        check("fadein_out_r",   int'(sig_out_r), 32);

        // Centre steady state
        run_samples(255, 16384, 0);
        check("centre_gain_l", int'(gain_l),    16384);
        check("centre_gain_r", int'(gain_r),    16384);
        run_samples(4, 16384, 0);
        check("centre_hold_gain_r", int'(gain_r),    16384);
        check("centre_out_l",       int'(sig_out_l), 8192);
        check("centre_out_r",       int'(sig_out_r), 8192);

        // Pan step from centre to full right
        do_sample(16384, 32767, lat);
        check("step1_gain_r", int'(gain_r),    16448);
        check("step1_gain_l", int'(gain_l),    16320);
        check("step1_out_r",  int'(sig_out_r), 8224);
        check("step1_out_l",  int'(sig_out_l), 8160);
        run_samples(254, 16384, 32767);
        check("step255_gain_r", int'(gain_r), 32704);
        do_sample(16384, 32767, lat);
        check("right_gain_r", int'(gain_r), 32767);
        check("right_gain_l", int'(gain_l), 1);

        // Full left extreme
        run_samples(512, 16384, -32768);
        check("left_settle_gain_l", int'(gain_l), 32767);
        check("left_settle_gain_r", int'(gain_r), 0);
        do_sample(-32768, -32768, lat);
        check("left_out_l",  int'(sig_out_l), -32767);
        check("left_out_r",  int'(sig_out_r), 0);
        check("left_gain_l", int'(gain_l),    32767);

        // Handshake: in_valid held high continuously
        @(negedge clk);
        sig_in   = 16'sd1000;
        pan      = 16'sd5000;
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_ready) acc.push_back(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("accept_count", acc.size(), 8);
        for (int i = 1; i < acc.size(); i++) check("accept_spacing", acc[i] - acc[i-1], 5);
        repeat (6) @(negedge clk);

        // Reset asserted while in MUL_L
        sig_in   = 16'sd20000;
        pan      = -16'sd1000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready",  int'(in_ready),  1);
        check("abort_out_l",     int'(sig_out_l), 0);
        check("abort_out_r",     int'(sig_out_r), 0);
        check("abort_gain_l",    int'(gain_l),    0);
        check("abort_gain_r",    int'(gain_r),    0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_valid",  seen,            0);
        check("abort_ready_rel", int'(in_ready),  1);

        // One more sample after the abort fades in again from zero gain
        do_sample(16384, 0, lat);
        check("post_abort_gain_l", int'(gain_l),    64);
        check("post_abort_out_r",  int'(sig_out_r), 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_pan2.md
# dsp_pan2

Mono-to-stereo panner: splits one audio sample stream into left/right outputs weighted by a pan control. It is the inverse of the two-input mixer and sits after a voice or effect chain, ahead of the stereo DAC path. Gains are slew-limited per sample to avoid zipper noise. A single time-shared multiplier is sequenced by a small FSM.

## Interface
- `BITS` (global define, typ. 16): sample, pan and gain width; all signed Q1.(BITS-1).
- `RAMP_STEP`, default 64: maximum gain change per accepted sample, in gain LSBs; must be ≥1.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: sample offered on `sig_in`.
- `in_ready` out 1: block can accept a sample.
- `sig_in` in BITS: signed mono input sample.
- `pan` in BITS: signed pan control; −2^(BITS−1) is full left, +2^(BITS−1)−1 is full right, 0 is centre.
- `out_valid` out 1: one-cycle pulse; `sig_out_l` and `sig_out_r` are updated.
- `sig_out_l` out BITS: signed left sample, held between pulses.
- `sig_out_r` out BITS: signed right sample, held between pulses.
- `gain_l` out BITS: current smoothed left gain (monitor).
- `gain_r` out BITS: current smoothed right gain (monitor).

## Operation
- Constants: HALF = 2^(BITS−2), GMAX = 2^(BITS−1)−1.
- Target gains:
  - p2 = `pan` >>> 1 (arithmetic shift).
  - tgt_r = HALF + p2.
  - tgt_l = HALF − p2, clamped to GMAX (only reached at pan = −2^(BITS−1)).
  - Both targets are always in 0..GMAX.
- Slew: each accepted sample moves each gain toward its target by min(|tgt−g|, RAMP_STEP). Gains never overshoot and stay in 0..GMAX.
- Product: out = (x·g) >>> (BITS−1).
  - Full-width (2·BITS) intermediate.
  - Truncation toward −∞.
  - No saturation is needed because 0 ≤ g < 1.
- FSM states: IDLE → RAMP → MUL_L → MUL_R → DONE → IDLE.
  - IDLE: `in_ready`=1. When `in_valid` is high, latch `sig_in` and `pan` and go to RAMP. Otherwise stay in IDLE.
  - RAMP: update `gain_l` and `gain_r` from the latched pan.
  - MUL_L: multiplier computes the left product into a holding register.
  - MUL_R: multiplier computes the right product.
  - DONE: `sig_out_l` and `sig_out_r` load together; `out_valid`=1 for exactly this cycle.
- Only one multiplier instance exists; it is shared by MUL_L and MUL_R.
- `in_ready`=0 in every state except IDLE. `in_valid` while not ready is ignored; the upstream must hold its sample.
- `pan` changes are sampled only at accept. The new gains apply to the same sample.
- Reset values (async on `rst_n` low): state IDLE, `in_ready`=1, `out_valid`=0, all outputs and gains 0. The first samples after reset therefore fade in.
- Reset mid-operation aborts the sample in progress. No `out_valid` is issued for it.

## Timing
- Accept happens at a rising edge where state=IDLE and `in_valid`=1; call this edge k.
- Edges k+1 through k+3: RAMP, MUL_L and MUL_R complete in turn.
- `out_valid` is high in the cycle following edge k+4. `sig_out_l`, `sig_out_r`, `gain_l` and `gain_r` are stable from that point.
- `gain_l`/`gain_r` update at edge k+1.
- `in_ready` returns high one cycle after DONE, so the next accept can occur at edge k+5.
- Throughput is one sample per 5 clocks; latency is 5 clocks from accept to `out_valid`.
- Outputs hold their values until the next DONE.

## Structure
- `dsp_pkg` holds:
  - HALF and GMAX derived from `BITS`;
  - the FSM state enum `pan_state_t`.
- Sub-module `dsp_slew`: one gain register with target input, step enable and RAMP_STEP limit. It is instantiated twice (left and right).
- The multiplier, output registers and FSM stay in `dsp_pan2`.

## Test plan
All cases use BITS=16, RAMP_STEP=64.
- **Reset fade-in:** after reset, pan=0, sig_in=16384, one sample → gain_l = gain_r = 64; sig_out_l = sig_out_r = 32; out_valid 5 cycles after accept.
- **Centre steady state:** pan=0, 256 samples of sig_in=16384 → gains settle at 16384 and never exceed it; outputs = 8192.
- **Full left extreme:** pan=−32768, gains pre-settled, sig_in=−32768 → gain_l=32767, gain_r=0; sig_out_l=−32767, sig_out_r=0.
- **Full right:** pan=32767, settled → gain_r=32767, gain_l=1.
- **Pan step from settled centre to full right:** per sample gain_r rises and gain_l falls by exactly 64, with no overshoot; the final step is smaller when the remaining distance is not a multiple of 64.
- **Handshake and reset:** in_valid held high continuously → accepts spaced exactly 5 cycles apart, in_ready low for 4 cycles after each accept. Assert rst_n low in MUL_L → no out_valid, all outputs 0, in_ready=1 after release.
